// File: rtl/mem_sync_sp_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_sync_sp_lsu
// Description : Load/store initiator for a synchronous single-port 64-bit data
//               memory. It handles one access at a time. Optional counters are
//               built when the MEM_SYNC_SP_LSU_STATS_EN macro is defined.
// Revision    : 1.0
// ============================================================================
module mem_sync_sp_lsu #(
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH+2:0]   req_addr,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_uns,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [7:0]              mem_wen,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [31:0]             stat_loads,
    output logic [31:0]             stat_stores,
    output logic [31:0]             stat_errs
);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("mem_sync_sp_lsu supports DATA_WIDTH = 64 only");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [2:0]              r_off;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic                    r_we;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_word;

    logic                    w_hs;
    logic [2:0]              w_mask;
    logic                    w_err;
    logic [7:0]              w_wen_pat;
    logic [63:0]             w_shift;
    logic [63:0]             w_fmt;
    logic [63:0]             w_rsp_data;

    assign req_ready = (r_state == S_IDLE);
    assign w_hs      = req_valid && (r_state == S_IDLE);
    assign w_err     = |(req_addr[2:0] & w_mask);
    assign mem_addr  = (r_state == S_IDLE) ? req_addr[ADDR_WIDTH+2:3] : r_word;
    assign mem_wen   = (w_hs && req_we && !w_err) ? w_wen_pat : 8'h00;

    always_comb begin
        w_mask    = 3'b111;
        w_wen_pat = 8'hFF;
        mem_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                w_mask    = 3'b000;
                w_wen_pat = 8'h01 << req_addr[2:0];
                mem_wdata = {8{req_wdata[7:0]}};
            end
            2'd1: begin
                w_mask    = 3'b001;
                w_wen_pat = 8'h03 << req_addr[2:0];
                mem_wdata = {4{req_wdata[15:0]}};
            end
            2'd2: begin
                w_mask    = 3'b011;
                w_wen_pat = 8'h0F << req_addr[2:0];
                mem_wdata = {2{req_wdata[31:0]}};
            end
            default: begin
                w_mask    = 3'b111;
                w_wen_pat = 8'hFF;
                mem_wdata = req_wdata;
            end
        endcase
    end

    // Read data is formatted with the request fields latched at handshake.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_size)
            2'd0:    w_fmt = r_uns ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
            2'd1:    w_fmt = r_uns ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
            2'd2:    w_fmt = r_uns ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
            default: w_fmt = mem_rdata;
        endcase
        w_rsp_data = (r_we || r_err) ? 64'd0 : w_fmt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_off     <= 3'd0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_word    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_off   <= req_addr[2:0];
                        r_size  <= req_size;
                        r_uns   <= req_uns;
                        r_we    <= req_we;
                        r_err   <= w_err;
                        r_word  <= req_addr[ADDR_WIDTH+2:3];
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rsp_rdata <= w_rsp_data;
                    rsp_err   <= r_err;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_SYNC_SP_LSU_STATS_EN
    logic [31:0] r_loads;
    logic [31:0] r_stores;
    logic [31:0] r_errs;

    // Misaligned accesses count only as errors, never as loads or stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loads  <= 32'd0;
            r_stores <= 32'd0;
            r_errs   <= 32'd0;
        end else if (w_hs) begin
            if (w_err)
                r_errs <= r_errs + 32'd1;
            else if (req_we)
                r_stores <= r_stores + 32'd1;
            else
                r_loads <= r_loads + 32'd1;
        end
    end

    assign stat_loads  = r_loads;
    assign stat_stores = r_stores;
    assign stat_errs   = r_errs;
`else
    assign stat_loads  = 32'd0;
    assign stat_stores = 32'd0;
    assign stat_errs   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_sp_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sync_sp_lsu
// Description : Bench for mem_sync_sp_lsu with a memory device, a byte-level
//               reference model and a per-cycle compare process.
// Revision    : 1.0
// ============================================================================
module tb_mem_sync_sp_lsu;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
`ifdef MEM_SYNC_SP_LSU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW+2:0] req_addr = '0;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_uns = 1'b0;
    logic [63:0]   req_wdata = 64'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wen;
    logic [63:0]   mem_rdata = 64'd0;
    logic [31:0]   stat_loads;
    logic [31:0]   stat_stores;
    logic [31:0]   stat_errs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_sync_sp_lsu #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_uns     (req_uns),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_rdata   (mem_rdata),
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_val(input int w);
        return {32'hA5000000 | 32'(w), 32'(w) * 32'h9E3779B9};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] en);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (en[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Write-first synchronous memory device.
    logic [63:0] mem [0:DEPTH-1];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= init_val(w);
            init_done <= 1'b1;
            mem_rdata <= 64'd0;
        end else begin
            mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_wen);
            mem_rdata     <= merge(mem[mem_addr], mem_wdata, mem_wen);
        end
    end

    // Reference model: flat byte-addressed memory plus expected responses.
    logic [7:0] refm [0:DEPTH*8-1];
    typedef struct {
        logic [63:0] rd;
        logic        er;
        int          word;
        int          due;
    } exp_t;
    exp_t q[$];
    int m_loads = 0, m_stores = 0, m_errs = 0;

    function automatic logic [63:0] model_load(input int a, input int sz, input bit uns);
        logic [63:0] v;
        int n;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refm[a+i];
        if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    initial begin : mon
        exp_t        e;
        bit          ev;
        int          a, sz, n;
        logic [7:0]  wen_e;
        logic [63:0] wd_e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_loads = 0; m_stores = 0; m_errs = 0;
                chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("rst_rsp_rdata", rsp_rdata, 64'd0);
                chk("rst_rsp_err", 64'(rsp_err), 64'd0);
                chk("rst_mem_wen", 64'(mem_wen), 64'd0);
                chk("rst_req_ready", 64'(req_ready), 64'd1);
            end else begin
                ev = (q.size() > 0) && (cyc >= q[0].due);
                chk("req_ready", 64'(req_ready), 64'(q.size() == 0));
                chk("rsp_valid", 64'(rsp_valid), 64'(ev));
                if (ev) begin
                    chk("rsp_rdata", rsp_rdata, q[0].rd);
                    chk("rsp_err", 64'(rsp_err), 64'(q[0].er));
                end
                if (q.size() == 0 && req_valid) begin
                    a  = int'(req_addr);
                    sz = int'(req_size);
                    n  = 1 << sz;
                    e.er = ((a % 8) % n) != 0;
                    wen_e = 8'h00;
                    for (int i = 0; i < 8; i++) wd_e[8*i +: 8] = req_wdata[8*(i % n) +: 8];
                    if (req_we && !e.er)
                        for (int i = 0; i < n; i++) wen_e[(a % 8) + i] = 1'b1;
                    chk("hs_mem_addr", 64'(mem_addr), 64'(a / 8));
                    chk("hs_mem_wen", 64'(mem_wen), 64'(wen_e));
                    if (req_we && !e.er) chk("hs_mem_wdata", mem_wdata, wd_e);
                    if (e.er) m_errs++;
                    else if (req_we) m_stores++;
                    else m_loads++;
                    if (req_we && !e.er)
                        for (int i = 0; i < n; i++) refm[a+i] = req_wdata[8*i +: 8];
                    e.rd   = (req_we || e.er) ? 64'd0 : model_load(a, sz, req_uns);
                    e.word = a / 8;
                    e.due  = cyc + 2;
                    q.push_back(e);
                end else begin
                    chk("mem_wen_quiet", 64'(mem_wen), 64'd0);
                    if (q.size() > 0) chk("mem_addr_hold", 64'(mem_addr), 64'(q[0].word));
                end
                if (ev && rsp_ready) void'(q.pop_front());
            end
        end
    end

    logic [7:0]  hs_wen;
    logic [AW-1:0] hs_addr;

    task automatic xact(input int a, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic er);
        int n;
        @(posedge clk); #1;
        req_addr = 14'(a); req_we = we; req_size = sz; req_uns = uns; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
        hs_wen  = mem_wen;
        hs_addr = mem_addr;
        @(posedge clk); #1;
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 14'($urandom);
        req_we    = 1'($urandom);
        req_wdata = {$urandom, $urandom};
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        if (!rsp_valid) chk("rsp_valid_timeout", 64'd0, 64'd1);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(posedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;

    initial begin
        for (int w = 0; w < DEPTH; w++)
            for (int b = 0; b < 8; b++) refm[8*w+b] = init_val(w)[8*b +: 8];
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Dword store then load
        xact(32'h40, 1'b1, 2'd3, 1'b0, 64'h1122334455667788, 0, rd, er);
        chk("t1_st_wen", 64'(hs_wen), 64'hFF);
        chk("t1_st_addr", 64'(hs_addr), 64'd8);
        chk("t1_st_rdata", rd, 64'd0);
        xact(32'h40, 1'b0, 2'd3, 1'b0, 64'd0, 0, rd, er);
        chk("t1_ld_rdata", rd, 64'h1122334455667788);
        chk("t1_ld_err", 64'(er), 64'd0);

        // Byte store, signed and unsigned loads
        xact(32'h43, 1'b1, 2'd0, 1'b0, 64'h80, 1, rd, er);
        chk("t2_st_wen", 64'(hs_wen), 64'h08);
        xact(32'h43, 1'b0, 2'd0, 1'b0, 64'd0, 0, rd, er);
        chk("t2_ld_signed", rd, 64'hFFFFFFFFFFFFFF80);
        xact(32'h43, 1'b0, 2'd0, 1'b1, 64'd0, 0, rd, er);
        chk("t2_ld_unsigned", rd, 64'h80);

        // Misaligned accesses
        xact(32'h41, 1'b0, 2'd1, 1'b0, 64'd0, 0, rd, er);
        chk("t3_ld_err", 64'(er), 64'd1);
        chk("t3_ld_rdata", rd, 64'd0);
        xact(32'h42, 1'b1, 2'd2, 1'b0, 64'hDEADBEEF, 0, rd, er);
        chk("t3_st_err", 64'(er), 64'd1);
        chk("t3_st_wen", 64'(hs_wen), 64'd0);
        xact(32'h40, 1'b0, 2'd3, 1'b0, 64'd0, 5, rd, er);
        chk("t3_readback", rd, 64'h1122334480667788);

        // Randomized traffic, with back-pressure on the response side
        for (int k = 0; k < 200; k++) begin
            int a;
            if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 16383));
            else a = int'($urandom_range(0, 15)) * 8 + int'($urandom_range(0, 7));
            xact(a, 1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom},
                 int'($urandom_range(0, 5)), rd, er);
        end

        // Reset while a load is in its WAIT cycle
        @(posedge clk); #1;
        req_addr = 14'h48; req_we = 1'b0; req_size = 2'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd1);

        // Counter scenario: 3 loads, 2 stores, 1 misaligned load
        xact(32'h00, 1'b0, 2'd3, 1'b0, 64'd0, 0, rd, er);
        xact(32'h08, 1'b0, 2'd2, 1'b0, 64'd0, 0, rd, er);
        xact(32'h10, 1'b0, 2'd1, 1'b1, 64'd0, 0, rd, er);
        xact(32'h18, 1'b1, 2'd3, 1'b0, 64'h0123456789ABCDEF, 0, rd, er);
        xact(32'h21, 1'b1, 2'd0, 1'b0, 64'h5A, 0, rd, er);
        xact(32'h2A, 1'b0, 2'd2, 1'b0, 64'd0, 0, rd, er);
        chk("t6_stat_loads", 64'(stat_loads), STATS ? 64'd3 : 64'd0);
        chk("t6_stat_stores", 64'(stat_stores), STATS ? 64'd2 : 64'd0);
        chk("t6_stat_errs", 64'(stat_errs), STATS ? 64'd1 : 64'd0);
        chk("model_loads", 64'(stat_loads), STATS ? 64'(m_loads) : 64'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
